// File: rtl/genie_mem_pkg.sv
// Shared constants and helpers for the GENIE external memory models.
// Widths here are upper bounds; callers size-cast to their own parameters.
package genie_mem_pkg;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 32;
    localparam int MAX_DATA_W = 1024;
    localparam int MAX_STRB_W = MAX_DATA_W / 8;

    // Bits needed to index n items; never returns less than 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] strb_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_STRB_W-1:0] strb
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MAX_STRB_W; b++) begin
            if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ext_sram_rd_chan.sv
// One read channel: RD_LATENCY-stage delay line, in-order response FIFO and
// an outstanding-request credit counter that keeps the FIFO from overflowing.
module ext_sram_rd_chan
    import genie_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = 3,
    parameter int MAX_OUT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rq_valid,
    output logic              rq_ready,
    input  logic [DATA_W-1:0] rd_word,
    output logic              rs_valid,
    input  logic              rs_ready,
    output logic [DATA_W-1:0] rs_data
);

    localparam int CNT_W = clog2(MAX_OUT + 1);
    localparam int PTR_W = clog2(MAX_OUT);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

    logic [CNT_W-1:0]      out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic                  rs_valid_q, rs_valid_d;
    logic [RD_LATENCY-1:0] dly_vld_q, dly_vld_d;
    logic [DATA_W-1:0]     dly_data_q [RD_LATENCY];
    logic [DATA_W-1:0]     dly_data_d [RD_LATENCY];
    logic [DATA_W-1:0]     fifo_mem   [MAX_OUT];
    logic                  accept, pop, push;

    assign rq_ready = (out_cnt_q < MAX_CNT) & ~rst;
    assign accept   = rq_valid & rq_ready;
    assign pop      = rs_valid_q & rs_ready;
    assign push     = dly_vld_q[RD_LATENCY-1];
    assign rs_valid = rs_valid_q;
    assign rs_data  = rs_valid_q ? fifo_mem[rd_ptr_q] : '0;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        dly_vld_d     = dly_vld_q << 1;
        dly_vld_d[0]  = accept;
        dly_data_d[0] = rd_word;
        for (int k = 1; k < RD_LATENCY; k++) dly_data_d[k] = dly_data_q[k-1];

        out_cnt_d = out_cnt_q;
        if (accept && !pop)      out_cnt_d = out_cnt_q + CNT_W'(1);
        else if (!accept && pop) out_cnt_d = out_cnt_q - CNT_W'(1);

        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)      fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
        else if (!push && pop) fifo_cnt_d = fifo_cnt_q - CNT_W'(1);

        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q;
        if (pop)  rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);

        rs_valid_d = (fifo_cnt_d != '0);
    end

    // NOTE: flops use non-blocking assignments so each one samples pre-edge values independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt_q  <= '0;
            fifo_cnt_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rs_valid_q <= 1'b0;
            dly_vld_q  <= '0;
        end else begin
            out_cnt_q  <= out_cnt_d;
            fifo_cnt_q <= fifo_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rs_valid_q <= rs_valid_d;
            dly_vld_q  <= dly_vld_d;
        end
    end

    // NOTE: data storage has no reset; the cleared valid bits and counters already mark it empty.
    always_ff @(posedge clk) begin
        dly_data_q <= dly_data_d;
        if (push) fifo_mem[wr_ptr_q] <= dly_data_q[RD_LATENCY-1];
        if (!rst) begin
            assert (!(push && !pop && fifo_cnt_q == MAX_CNT))
                else $fatal(1, "ext_sram_rd_chan: response FIFO overflow");
        end
    end

endmodule

// File: rtl/ext_sram_mc.sv
// Multi-channel behavioural external SRAM: NUM_RD credit-limited read channels
// and one strobed write channel with a fixed-latency commit pipeline.
module ext_sram_mc
    import genie_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int NUM_RD     = 2,
    parameter int RD_LATENCY = 3,
    parameter int WR_LATENCY = 4,
    parameter int MAX_OUT    = 4,
    parameter int WR_DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_valid,
    output logic                     w_ready,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [DATA_W/8-1:0]      w_strb,
    input  logic [NUM_RD-1:0]        rq_valid,
    output logic [NUM_RD-1:0]        rq_ready,
    input  logic [NUM_RD*ADDR_W-1:0] rq_addr,
    output logic [NUM_RD-1:0]        rs_valid,
    input  logic [NUM_RD-1:0]        rs_ready,
    output logic [NUM_RD*DATA_W-1:0] rs_data
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WCNT_W = clog2(WR_DEPTH + 1);
    localparam logic [WCNT_W-1:0] WR_MAX = WCNT_W'(WR_DEPTH);

    if (RD_LATENCY < 1 || WR_LATENCY < 1) begin : g_bad_latency
        $fatal(1, "ext_sram_mc: RD_LATENCY and WR_LATENCY must be >= 1");
    end
    if (DATA_W % 8 != 0 || DATA_W > MAX_DATA_W) begin : g_bad_width
        $fatal(1, "ext_sram_mc: DATA_W must be a multiple of 8 and <= MAX_DATA_W");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $fatal(1, "ext_sram_mc: NUM_RD must be 1..4");
    end

    logic [DATA_W-1:0] ram [2**ADDR_W];

    logic [WR_LATENCY-1:0] wp_vld_q, wp_vld_d;
    logic [ADDR_W-1:0]     wp_addr_q [WR_LATENCY];
    logic [ADDR_W-1:0]     wp_addr_d [WR_LATENCY];
    logic [DATA_W-1:0]     wp_data_q [WR_LATENCY];
    logic [DATA_W-1:0]     wp_data_d [WR_LATENCY];
    logic [STRB_W-1:0]     wp_strb_q [WR_LATENCY];
    logic [STRB_W-1:0]     wp_strb_d [WR_LATENCY];
    logic [WCNT_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic                  w_accept, commit_vld, commit_en;
    logic [ADDR_W-1:0]     commit_addr;
    logic [DATA_W-1:0]     commit_word;

    assign w_ready     = (wr_cnt_q < WR_MAX) & ~rst;
    assign w_accept    = w_valid & w_ready;
    assign commit_vld  = wp_vld_q[WR_LATENCY-1];
    // A write still in the pipeline when reset hits must never reach ram.
    assign commit_en   = commit_vld & ~rst;
    assign commit_addr = wp_addr_q[WR_LATENCY-1];
    assign commit_word = DATA_W'(strb_merge(MAX_DATA_W'(ram[commit_addr]),
                                            MAX_DATA_W'(wp_data_q[WR_LATENCY-1]),
                                            MAX_STRB_W'(wp_strb_q[WR_LATENCY-1])));

    always_comb begin
        wp_vld_d     = wp_vld_q << 1;
        wp_vld_d[0]  = w_accept;
        wp_addr_d[0] = w_addr;
        wp_data_d[0] = w_data;
        wp_strb_d[0] = w_strb;
        for (int k = 1; k < WR_LATENCY; k++) begin
            wp_addr_d[k] = wp_addr_q[k-1];
            wp_data_d[k] = wp_data_q[k-1];
            wp_strb_d[k] = wp_strb_q[k-1];
        end

        wr_cnt_d = wr_cnt_q;
        if (w_accept && !commit_vld)      wr_cnt_d = wr_cnt_q + WCNT_W'(1);
        else if (!w_accept && commit_vld) wr_cnt_d = wr_cnt_q - WCNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_vld_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            wp_vld_q <= wp_vld_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        wp_addr_q <= wp_addr_d;
        wp_data_q <= wp_data_d;
        wp_strb_q <= wp_strb_d;
        if (commit_en) ram[commit_addr] <= commit_word;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_word;

        assign rd_addr = rq_addr[i*ADDR_W +: ADDR_W];

        // A commit on the same edge as the accept is visible to the read.
        always_comb begin
            rd_word = ram[rd_addr];
            if (commit_en && commit_addr == rd_addr) rd_word = commit_word;
            if ($isunknown(rd_addr)) rd_word = 'x;
        end

        always_ff @(posedge clk) begin
            if (!rst && rq_valid[i] && rq_ready[i]) begin
                assert (!$isunknown(rd_addr))
                    else $error("ext_sram_mc: unknown read address on channel %0d", i);
            end
        end

        ext_sram_rd_chan #(
            .DATA_W     (DATA_W),
            .RD_LATENCY (RD_LATENCY),
            .MAX_OUT    (MAX_OUT)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .rq_valid (rq_valid[i]),
            .rq_ready (rq_ready[i]),
            .rd_word  (rd_word),
            .rs_valid (rs_valid[i]),
            .rs_ready (rs_ready[i]),
            .rs_data  (rs_data[i*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_ext_sram_mc.sv
// Directed bench for ext_sram_mc: reset, read latency, credits, byte strobes,
// write pipeline depth, parallel channels and reset with traffic in flight.
module tb_ext_sram_mc;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int RL = 3;
    localparam int WL = 4;
    localparam int MO = 4;
    localparam int WD = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             w_valid, w_ready;
    logic [AW-1:0]    w_addr;
    logic [DW-1:0]    w_data;
    logic [DW/8-1:0]  w_strb;
    logic [NR-1:0]    rq_valid, rq_ready, rs_valid, rs_ready;
    logic [NR*AW-1:0] rq_addr;
    logic [NR*DW-1:0] rs_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ext_sram_mc #(
        .ADDR_W (AW), .DATA_W (DW), .NUM_RD (NR), .RD_LATENCY (RL),
        .WR_LATENCY (WL), .MAX_OUT (MO), .WR_DEPTH (WD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .w_strb   (w_strb),
        .rq_valid (rq_valid),
        .rq_ready (rq_ready),
        .rq_addr  (rq_addr),
        .rs_valid (rs_valid),
        .rs_ready (rs_ready),
        .rs_data  (rs_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s);
        int n;
        n = 0;
        w_valid = 1'b1; w_addr = a; w_data = d; w_strb = s;
        while (!w_ready && n < 50) begin tick(); n++; end
        if (!w_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL write_accept_timeout addr=%h: w_ready=%b required 1", a, w_ready);
        end
        tick();
        w_valid = 1'b0;
    endtask

    task automatic drain_writes();
        repeat (WL + 2) tick();
    endtask

    task automatic read_word(input int ch, input logic [AW-1:0] a, output logic [DW-1:0] d);
        int n;
        rs_ready[ch] = 1'b1;
        rq_valid[ch] = 1'b1;
        rq_addr[ch*AW +: AW] = a;
        n = 0;
        while (!rq_ready[ch] && n < 50) begin tick(); n++; end
        tick();
        rq_valid[ch] = 1'b0;
        n = 0;
        while (!rs_valid[ch] && n < 50) begin tick(); n++; end
        if (!rs_valid[ch]) begin
            tests_run++; tests_failed++;
            $display("FAIL read_resp_timeout ch=%0d addr=%h: rs_valid=0 required 1", ch, a);
            d = 'x;
        end else begin
            d = rs_data[ch*DW +: DW];
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        tests_run++;
        if (w_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_w_ready: got %b required 0", w_ready); end
        tests_run++;
        if (rq_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_rq_ready: got %b required 00", rq_ready); end
        tests_run++;
        if (rs_valid !== 2'b00) begin tests_failed++; $display("FAIL reset_rs_valid: got %b required 00", rs_valid); end
        tests_run++;
        if (rs_data !== '0) begin tests_failed++; $display("FAIL reset_rs_data: got %h required 0", rs_data); end
        rst = 1'b0;
        #1;
        tests_run++;
        if (rq_ready !== 2'b11) begin tests_failed++; $display("FAIL release_rq_ready: got %b required 11", rq_ready); end
        tests_run++;
        if (w_ready !== 1'b1) begin tests_failed++; $display("FAIL release_w_ready: got %b required 1", w_ready); end
        tick();
    endtask

    task automatic test_single_read();
        write_word(8'h10, 32'hDEADBEEF, 4'hF);
        drain_writes();
        rs_ready = 2'b00;
        rq_valid[0] = 1'b1;
        rq_addr[0 +: AW] = 8'h10;
        tests_run++;
        if (rq_ready[0] !== 1'b1) begin tests_failed++; $display("FAIL single_rq_ready: got %b required 1", rq_ready[0]); end
        tick();
        rq_valid[0] = 1'b0;
        for (int k = 0; k < RL; k++) begin
            tests_run++;
            if (rs_valid[0] !== 1'b0) begin
                tests_failed++; $display("FAIL single_early_valid cycle %0d: got %b required 0", k, rs_valid[0]);
            end
            tick();
        end
        tests_run++;
        if (rs_valid[0] !== 1'b1) begin tests_failed++; $display("FAIL single_valid_at_latency: got %b required 1", rs_valid[0]); end
        tests_run++;
        if (rs_data[0 +: DW] !== 32'hDEADBEEF) begin
            tests_failed++; $display("FAIL single_data: got %h required deadbeef", rs_data[0 +: DW]);
        end
        rs_ready[0] = 1'b1;
        tick();
        tests_run++;
        if (rs_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL single_pop: got %b required 0", rs_valid[0]); end
    endtask

    task automatic test_credit_backpressure();
        logic [DW-1:0] got [6];
        int a, acc, nresp;
        logic acc_now;
        for (int i = 0; i < 6; i++) write_word(AW'(i), 32'hA000_0000 + i, 4'hF);
        drain_writes();
        rs_ready[1] = 1'b0;
        a = 0; acc = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            rq_valid[1] = 1'b1;
            rq_addr[AW +: AW] = AW'(a);
            acc_now = rq_ready[1];
            tick();
            if (acc_now) begin acc++; a++; end
        end
        tests_run++;
        if (acc != 4) begin tests_failed++; $display("FAIL credit_accept_count: got %0d required 4", acc); end
        tests_run++;
        if (rq_ready[1] !== 1'b0) begin tests_failed++; $display("FAIL credit_rq_ready_low: got %b required 0", rq_ready[1]); end
        tests_run++;
        if (rs_data[DW +: DW] !== 32'hA000_0000) begin
            tests_failed++; $display("FAIL credit_head_held: got %h required a0000000", rs_data[DW +: DW]);
        end
        rs_ready[1] = 1'b1;
        nresp = 0;
        for (int cyc = 0; cyc < 60 && nresp < 6; cyc++) begin
            if (rs_valid[1]) begin got[nresp] = rs_data[DW +: DW]; nresp++; end
            rq_valid[1] = (a < 6);
            rq_addr[AW +: AW] = AW'(a);
            acc_now = (a < 6) && rq_ready[1];
            tick();
            if (acc_now) a++;
        end
        rq_valid[1] = 1'b0;
        tests_run++;
        if (a != 6 || nresp != 6) begin
            tests_failed++; $display("FAIL credit_drain: accepted %0d responses %0d required 6 and 6", a, nresp);
        end
        for (int k = 0; k < nresp; k++) begin
            tests_run++;
            if (got[k] !== 32'hA000_0000 + k) begin
                tests_failed++; $display("FAIL credit_order[%0d]: got %h required %h", k, got[k], 32'hA000_0000 + k);
            end
        end
    endtask

    task automatic test_strobe_write();
        logic [DW-1:0] d0, d1;
        logic got0, got1;
        write_word(8'h20, 32'h11223344, 4'hF);
        drain_writes();
        rs_ready = 2'b11;
        w_valid = 1'b1; w_addr = 8'h20; w_data = 32'hAABBCCDD; w_strb = 4'b0101;
        tests_run++;
        if (w_ready !== 1'b1) begin tests_failed++; $display("FAIL strobe_w_ready: got %b required 1", w_ready); end
        tick();
        w_valid = 1'b0;
        tick(); tick();
        rq_valid[0] = 1'b1; rq_addr[0 +: AW] = 8'h20;
        tick();
        rq_valid[0] = 1'b0;
        rq_valid[1] = 1'b1; rq_addr[AW +: AW] = 8'h20;
        tick();
        rq_valid[1] = 1'b0;
        got0 = 1'b0; got1 = 1'b0; d0 = '0; d1 = '0;
        for (int cyc = 0; cyc < 20 && !(got0 && got1); cyc++) begin
            if (rs_valid[0] && !got0) begin d0 = rs_data[0 +: DW]; got0 = 1'b1; end
            if (rs_valid[1] && !got1) begin d1 = rs_data[DW +: DW]; got1 = 1'b1; end
            tick();
        end
        tests_run++;
        if (!got0 || d0 !== 32'h11223344) begin
            tests_failed++; $display("FAIL strobe_before_commit: valid %b data %h required 11223344", got0, d0);
        end
        tests_run++;
        if (!got1 || d1 !== 32'h11BB33DD) begin
            tests_failed++; $display("FAIL strobe_at_commit: valid %b data %h required 11bb33dd", got1, d1);
        end
    endtask

    task automatic test_write_full();
        logic [AW-1:0] wa [5] = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h40};
        logic [DW-1:0] exp_rd [4] = '{32'h5, 32'h2, 32'h3, 32'h4};
        logic [DW-1:0] d;
        int idx, stall;
        logic acc_now, ready_after4;
        idx = 0; stall = 0; ready_after4 = 1'b1;
        for (int cyc = 0; cyc < 30 && idx < 5; cyc++) begin
            w_valid = 1'b1; w_addr = wa[idx]; w_data = DW'(idx + 1); w_strb = 4'hF;
            acc_now = w_ready;
            if (!acc_now) stall++;
            tick();
            if (acc_now) begin
                idx++;
                if (idx == 4) ready_after4 = w_ready;
            end
        end
        w_valid = 1'b0;
        tests_run++;
        if (idx != 5) begin tests_failed++; $display("FAIL wfull_accepts: got %0d required 5", idx); end
        tests_run++;
        if (ready_after4 !== 1'b0) begin tests_failed++; $display("FAIL wfull_ready_low: got %b required 0", ready_after4); end
        tests_run++;
        if (stall != 1) begin tests_failed++; $display("FAIL wfull_stall_cycles: got %0d required 1", stall); end
        drain_writes();
        for (int k = 0; k < 4; k++) begin
            read_word(0, AW'(8'h40 + k), d);
            tests_run++;
            if (d !== exp_rd[k]) begin
                tests_failed++; $display("FAIL wfull_readback addr %h: got %h required %h", 8'h40 + k, d, exp_rd[k]);
            end
        end
    endtask

    task automatic test_parallel();
        write_word(8'h30, 32'hCAFEF00D, 4'hF);
        drain_writes();
        rs_ready = 2'b01;
        rq_valid = 2'b11;
        rq_addr = {8'h30, 8'h30};
        tick();
        rq_valid = 2'b00;
        tick(); tick();
        tests_run++;
        if (rs_valid !== 2'b00) begin tests_failed++; $display("FAIL par_early_valid: got %b required 00", rs_valid); end
        tick();
        tests_run++;
        if (rs_valid !== 2'b11) begin tests_failed++; $display("FAIL par_valid: got %b required 11", rs_valid); end
        tests_run++;
        if (rs_data[0 +: DW] !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL par_ch0_data: got %h required cafef00d", rs_data[0 +: DW]);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            tests_run++;
            if (rs_valid[1] !== 1'b1 || rs_data[DW +: DW] !== 32'hCAFEF00D) begin
                tests_failed++;
                $display("FAIL par_ch1_hold cycle %0d: valid %b data %h required 1 cafef00d", k, rs_valid[1], rs_data[DW +: DW]);
            end
        end
        tests_run++;
        if (rs_valid[0] !== 1'b0) begin tests_failed++; $display("FAIL par_ch0_popped: got %b required 0", rs_valid[0]); end
        rs_ready[1] = 1'b1;
        tick();
        tests_run++;
        if (rs_valid[1] !== 1'b0) begin tests_failed++; $display("FAIL par_ch1_pop: got %b required 0", rs_valid[1]); end
    endtask

    task automatic test_reset_midop();
        logic [DW-1:0] d;
        write_word(8'h50, 32'h55555555, 4'hF);
        write_word(8'h51, 32'h66666666, 4'hF);
        drain_writes();
        rs_ready = 2'b11;
        rq_valid = 2'b11; rq_addr = {8'h50, 8'h50};
        w_valid = 1'b1; w_addr = 8'h50; w_data = 32'h12345678; w_strb = 4'hF;
        tick();
        rq_valid = 2'b01; rq_addr[0 +: AW] = 8'h51;
        w_addr = 8'h51; w_data = 32'h9ABCDEF0;
        tick();
        rq_valid = 2'b00; w_valid = 1'b0;
        rst = 1'b1;
        tick();
        tests_run++;
        if (w_ready !== 1'b0 || rq_ready !== 2'b00) begin
            tests_failed++; $display("FAIL midrst_ready_low: w_ready %b rq_ready %b required 0 00", w_ready, rq_ready);
        end
        tests_run++;
        if (rs_valid !== 2'b00 || rs_data !== '0) begin
            tests_failed++; $display("FAIL midrst_outputs: rs_valid %b rs_data %h required 00 0", rs_valid, rs_data);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (rq_ready !== 2'b11 || w_ready !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_release: rq_ready %b w_ready %b required 11 1", rq_ready, w_ready);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            tests_run++;
            if (rs_valid !== 2'b00) begin
                tests_failed++; $display("FAIL midrst_stale_resp cycle %0d: got %b required 00", k, rs_valid);
            end
        end
        read_word(0, 8'h50, d);
        tests_run++;
        if (d !== 32'h55555555) begin tests_failed++; $display("FAIL midrst_write_dropped_50: got %h required 55555555", d); end
        read_word(1, 8'h51, d);
        tests_run++;
        if (d !== 32'h66666666) begin tests_failed++; $display("FAIL midrst_write_dropped_51: got %h required 66666666", d); end
    endtask

    initial begin
        rst = 1'b1;
        w_valid = 1'b0; w_addr = '0; w_data = '0; w_strb = '0;
        rq_valid = '0; rq_addr = '0; rs_ready = '0;
        test_reset();
        test_single_read();
        test_credit_backpressure();
        test_strobe_write();
        test_write_full();
        test_parallel();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
